tone_generator: RTL and testbench
=================================

# tone_generator

Converts the note/octave stream produced by the mode controller into a square-wave speaker drive. Sits between the controller's `note_out`/`octave_out` registers and the buzzer pin. Resolves each note code to a half-period count and toggles the speaker output on that count. A small state machine switches notes glitch-free and inserts a short articulation gap between different notes.

## Interface
- `GAP_CYCLES`, default 1_000_000: silence inserted between two different sounding notes (10 ms at 100 MHz); 0 disables the gap.
- `DIV_SHIFT`, default 0: right-shift applied to every half-period. Used only to shorten simulation; must be 0 in synthesis.
- `clk`  in  1  system clock, 100 MHz (the half-period table is fixed for 100 MHz).
- `reset`  in  1  synchronous, active-low.
- `note`  in  4  1..7 = do..si; 0 and 8..15 = rest.
- `octave`  in  2  0 = low, 1 = mid, 2 = high, 3 = treated as mid.
- `mute`  in  1  forces silence immediately.
- `speaker`  out  1  square-wave drive to the buzzer.
- `sounding`  out  1  high while in PLAY.
- `cur_note`  out  4  note currently sounding; 0 when silent.
- `cur_octave`  out  2  octave currently sounding; 0 when silent.

## Operation
- Mid-octave half-periods in cycles:
  - C 191113
  - D 170262
  - E 151686
  - F 143173
  - G 127551
  - A 113636
  - B 101239
- Octave scaling: low = value << 1; high = value >> 1; octave 3 = mid.
- DIV_SHIFT is applied after octave scaling: H = scaled >> DIV_SHIFT. If the result is 0, H is clamped to 1.
- H is 19 bits wide; the largest value is low C = 382226.
- A request is "valid" when `note` is in 1..7 and `mute` = 0.
- States: IDLE, PLAY, GAP.
- IDLE:
  - `speaker` = 0, `sounding` = 0, `cur_note` = 0, `cur_octave` = 0.
  - On a valid request: latch `note`/`octave` into `cur_note`/`cur_octave`, load H, clear `cnt`, set `speaker` = 1, go to PLAY.
- PLAY:
  - `cnt` increments every cycle.
  - When `cnt` == H−1 (a boundary): `cnt` ← 0, then evaluate the inputs.
  - Same note and octave: toggle `speaker`, stay in PLAY.
  - Rest: `speaker` ← 0, go to IDLE.
  - Different valid request with GAP_CYCLES > 0: `speaker` ← 0, clear `cur_note`/`cur_octave`, start the gap counter, go to GAP.
  - Different valid request with GAP_CYCLES = 0: latch the new note, load the new H, `speaker` ← 1, stay in PLAY.
  - Input changes between boundaries are ignored. This prevents runt pulses.
- GAP:
  - `speaker` = 0.
  - The gap counter counts GAP_CYCLES cycles.
  - On expiry with a valid request: behave exactly as IDLE's entry into PLAY.
  - On expiry otherwise: go to IDLE.
- `mute` = 1 in any state: next edge goes to IDLE, `speaker` ← 0, all counters cleared. This does not wait for a boundary.
- `reset` = 0 has priority over everything and produces the IDLE reset values.

## Timing
- Reset values:
  - `speaker` 0, `sounding` 0, `cur_note` 0, `cur_octave` 0.
  - state IDLE, `cnt` 0, gap counter 0.
- All outputs are registered.
- Start latency: a valid request seen at IDLE edge k gives `speaker` = 1 and `sounding` = 1 after edge k.
- Tone shape: `speaker` toggles at edges k+H, k+2H, … Each level lasts exactly H cycles.
- Rest/change latency: at most H cycles, always taken at a boundary.
- GAP length: `speaker` is low for exactly GAP_CYCLES cycles after the boundary edge. The new note starts on the following edge.
- `mute` latency: 1 cycle.
- Reset latency: 1 cycle, including mid-PLAY and mid-GAP.
- Simultaneous mute and boundary: mute wins. Simultaneous reset and mute: reset wins.

## Structure
- Package `tone_pkg` contains:
  - The 7 mid-octave half-period constants.
  - `HALF_W` = 19.
  - Note codes NOTE_REST = 0, NOTE_DO = 1 … NOTE_SI = 7.
  - Octave codes.
  - The state encoding (IDLE, PLAY, GAP).
- Sub-module `tone_period_lut`: combinational; maps `note`, `octave` and DIV_SHIFT to H, including the clamp to ≥1.
- Top level contains the FSM, the half-period counter and the gap counter.

## Test plan
- Reset, then hold `note`=6, `octave`=1, DIV_SHIFT=10. Required: `speaker` rises the cycle after the request, then toggles every 110 cycles; `sounding`=1; `cur_note`=6.
- DIV_SHIFT=10, `note`=1, `octave`=0, then `octave`=2 with `note`=7. Required: low C gives 373-cycle levels; high B gives 49-cycle levels.
- While playing A, switch to C with GAP_CYCLES=20. Required: A finishes its current half-period; `speaker` is low for 20 cycles; C then starts with `cur_note`=1. With GAP_CYCLES=0, C starts at the A boundary with no low gap.
- Assert `mute` mid-half-period. Required: next cycle `speaker`=0, `sounding`=0, state IDLE. Deassert `mute` with a valid note: restart after 1 cycle.
- Change `note` to 0 mid-half-period. Required: output holds until the boundary, then `speaker`=0 and IDLE. Also drive `note`=9 and `octave`=3: 9 is silent; 3 plays as mid.
- Pulse `reset` low during PLAY and during GAP. Required: all reset values after 1 cycle; no residual toggle.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared half-period table, note/octave codes and FSM states for tone_generator
package tone_pkg;
  localparam int HALF_W = 19;
  localparam logic [HALF_W-1:0] HALF_DO  = 19'd191113;
  localparam logic [HALF_W-1:0] HALF_RE  = 19'd170262;
  localparam logic [HALF_W-1:0] HALF_MI  = 19'd151686;
  localparam logic [HALF_W-1:0] HALF_FA  = 19'd143173;
  localparam logic [HALF_W-1:0] HALF_SOL = 19'd127551;
  localparam logic [HALF_W-1:0] HALF_LA  = 19'd113636;
  localparam logic [HALF_W-1:0] HALF_SI  = 19'd101239;
  localparam logic [HALF_W-1:0] HALF_MID [8] = '{19'd0, HALF_DO, HALF_RE, HALF_MI, HALF_FA, HALF_SOL, HALF_LA, HALF_SI};
  typedef enum logic [3:0] {
    NOTE_REST, NOTE_DO, NOTE_RE, NOTE_MI, NOTE_FA, NOTE_SOL, NOTE_LA, NOTE_SI
  } note_t;
  typedef enum logic [1:0] {OCT_LOW, OCT_MID, OCT_HIGH, OCT_ALT} octave_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  function automatic logic is_tone(input logic [3:0] n);
    return n >= NOTE_DO && n <= NOTE_SI;
  endfunction
endpackage

// File: rtl/tone_period_lut.sv
// tone_period_lut: note/octave to half-period count, scaled and clamped to at least 1
import tone_pkg::*;
module tone_period_lut #(
  parameter int DIV_SHIFT = 0
) (
  input  logic [3:0]        note,
  input  logic [1:0]        octave,
  output logic [HALF_W-1:0] half
);
  logic [HALF_W-1:0] base, scaled, shifted;
  always_comb begin
    base = is_tone(note) ? HALF_MID[note[2:0]] : '0;
    scaled = octave == OCT_LOW ? base << 1 : octave == OCT_HIGH ? base >> 1 : base;
    shifted = scaled >> DIV_SHIFT;
    half = shifted == '0 ? HALF_W'(1) : shifted;
  end
endmodule

// File: rtl/tone_generator.sv
// tone_generator: square-wave buzzer drive with boundary-only note changes and an articulation gap
import tone_pkg::*;
module tone_generator #(
  parameter int GAP_CYCLES = 1_000_000,
  parameter int DIV_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  input  logic       mute,
  output logic       speaker,
  output logic       sounding,
  output logic [3:0] cur_note,
  output logic [1:0] cur_octave
);
  state_t state;
  logic [HALF_W-1:0] half, half_new, cnt;
  logic [31:0] gcnt;
  logic valid, boundary, same, gap_done, start;
  tone_period_lut #(.DIV_SHIFT(DIV_SHIFT)) lut (.note(note), .octave(octave), .half(half_new));
  assign valid = is_tone(note) && !mute;
  assign boundary = cnt == half - 1'b1;
  assign same = note == cur_note && octave == cur_octave;
  assign gap_done = gcnt == 32'(GAP_CYCLES - 1);
  // every path into PLAY (from IDLE, gap expiry or a gapless change) shares one load
  assign start = valid && (state == IDLE || (state == GAP && gap_done) ||
                 (state == PLAY && boundary && !same && GAP_CYCLES == 0));
  assign sounding = state == PLAY;
  always_ff @(posedge clk) begin
    if (!reset || mute) begin
      state <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      half <= '0;
      speaker <= 1'b0;
      cur_note <= '0;
      cur_octave <= '0;
    end else if (start) begin
      state <= PLAY;
      cnt <= '0;
      gcnt <= '0;
      half <= half_new;
      speaker <= 1'b1;
      cur_note <= note;
      cur_octave <= octave;
    end else begin
      case (state)
        PLAY: begin
          cnt <= boundary ? '0 : cnt + 1'b1;
          if (boundary && same) begin
            speaker <= ~speaker;
          end else if (boundary) begin
            state <= is_tone(note) ? GAP : IDLE;
            gcnt <= '0;
            speaker <= 1'b0;
            cur_note <= '0;
            cur_octave <= '0;
          end
        end
        GAP: begin
          gcnt <= gap_done ? '0 : gcnt + 1'b1;
          state <= gap_done ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: directed table, corner sequences and random stimulus against a time-based reference model
module tb_tone_generator;
  localparam int SHIFT = 10;
  localparam int GAPS [2] = '{20, 0};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] note = '0;
  logic [1:0] octave = '0;
  logic mute = 1'b0;
  logic o_spk [2];
  logic o_snd [2];
  logic [3:0] o_note [2];
  logic [1:0] o_oct [2];
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  bit m_play [2];
  bit m_gap [2];
  bit m_spk [2];
  bit [3:0] m_n [2];
  bit [1:0] m_o [2];
  int m_h [2];
  longint m_nxt [2];

  tone_generator #(.GAP_CYCLES(20), .DIV_SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .note(note), .octave(octave), .mute(mute),
    .speaker(o_spk[0]), .sounding(o_snd[0]), .cur_note(o_note[0]), .cur_octave(o_oct[0]));
  tone_generator #(.GAP_CYCLES(0), .DIV_SHIFT(SHIFT)) dut0 (
    .clk(clk), .reset(reset), .note(note), .octave(octave), .mute(mute),
    .speaker(o_spk[1]), .sounding(o_snd[1]), .cur_note(o_note[1]), .cur_octave(o_oct[1]));

  always #5 clk = ~clk;

  function automatic int half_of(input logic [3:0] n, input logic [1:0] o);
    int base [8] = '{0, 191113, 170262, 151686, 143173, 127551, 113636, 101239};
    int s;
    s = (n >= 1 && n <= 7) ? base[n[2:0]] : 0;
    s = o == 0 ? s * 2 : o == 2 ? s / 2 : s;
    s = s >> SHIFT;
    return s == 0 ? 1 : s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic m_start(input int i);
    m_play[i] = 1; m_gap[i] = 0; m_spk[i] = 1;
    m_n[i] = note; m_o[i] = octave;
    m_h[i] = half_of(note, octave);
    m_nxt[i] = cyc + m_h[i];
  endtask

  task automatic m_silence(input int i);
    m_play[i] = 0; m_gap[i] = 0; m_spk[i] = 0; m_n[i] = 0; m_o[i] = 0;
  endtask

  // tone events are tracked as absolute edge times rather than running counters
  task automatic m_step(input int i);
    bit tone, valid;
    tone = note >= 1 && note <= 7;
    valid = tone && !mute;
    if (!reset || mute) m_silence(i);
    else if (m_gap[i]) begin
      if (cyc == m_nxt[i]) begin
        if (valid) m_start(i); else m_silence(i);
      end
    end else if (m_play[i]) begin
      if (cyc == m_nxt[i]) begin
        if (note == m_n[i] && octave == m_o[i]) begin
          m_spk[i] = ~m_spk[i];
          m_nxt[i] = cyc + m_h[i];
        end else if (!tone) m_silence(i);
        else if (GAPS[i] > 0) begin
          m_silence(i);
          m_gap[i] = 1;
          m_nxt[i] = cyc + GAPS[i];
        end else m_start(i);
      end
    end else if (valid) m_start(i);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) m_step(i);
    #1;
    check("model_gap20", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]}, {24'd0, m_spk[0], m_play[0], m_n[0], m_o[0]});
    check("model_gap0", {24'd0, o_spk[1], o_snd[1], o_note[1], o_oct[1]}, {24'd0, m_spk[1], m_play[1], m_n[1], m_o[1]});
  endtask

  task automatic do_reset();
    reset = 0; note = 0; octave = 0; mute = 0;
    tick();
    reset = 1;
  endtask

  typedef struct {
    logic [3:0] n;
    logic [1:0] o;
    logic [3:0] cn;
    logic [1:0] co;
    logic snd;
    int h;
  } vec_t;

  initial begin
    vec_t tbl [10];
    longint s;
    int len;
    tbl = '{
      '{4'd6, 2'd1, 4'd6, 2'd1, 1'b1, 110},
      '{4'd1, 2'd0, 4'd1, 2'd0, 1'b1, 373},
      '{4'd7, 2'd2, 4'd7, 2'd2, 1'b1, 49},
      '{4'd1, 2'd3, 4'd1, 2'd3, 1'b1, 186},
      '{4'd5, 2'd2, 4'd5, 2'd2, 1'b1, 62},
      '{4'd3, 2'd0, 4'd3, 2'd0, 1'b1, 296},
      '{4'd2, 2'd1, 4'd2, 2'd1, 1'b1, 166},
      '{4'd4, 2'd2, 4'd4, 2'd2, 1'b1, 69},
      '{4'd9, 2'd3, 4'd0, 2'd0, 1'b0, 0},
      '{4'd0, 2'd1, 4'd0, 2'd0, 1'b0, 0}};
    for (int i = 0; i < 2; i++) begin
      m_silence(i); m_h[i] = 1; m_nxt[i] = 0;
    end
    do_reset();
    check("reset_outputs", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]}, 32'd0);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      note = tbl[v].n; octave = tbl[v].o;
      tick();
      check("start_state", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]},
            {24'd0, tbl[v].snd, tbl[v].snd, tbl[v].cn, tbl[v].co});
      if (tbl[v].snd) begin
        len = 1;
        while (o_spk[0] && len < 1000) begin
          tick();
          if (o_spk[0]) len++;
        end
        check("high_level_len", len, tbl[v].h);
        len = 1;
        while (!o_spk[0] && len < 1000) begin
          tick();
          if (!o_spk[0]) len++;
        end
        check("low_level_len", len, tbl[v].h);
      end else repeat (5) tick();
    end

    // A to C change: gap on one instance, immediate switch on the other
    do_reset();
    note = 6; octave = 1;
    tick();
    s = cyc;
    repeat (30) tick();
    note = 1;
    len = 0;
    while (o_snd[0] && len < 500) begin tick(); len++; end
    check("a_boundary", 32'(cyc - s), 32'd110);
    check("gapless_switch", {24'd0, o_spk[1], o_snd[1], o_note[1], o_oct[1]}, {24'd0, 1'b1, 1'b1, 4'd1, 2'd1});
    len = 1;
    while (!o_snd[0] && len < 500) begin
      tick();
      if (!o_snd[0]) len++;
    end
    check("gap_len", len, 20);
    check("after_gap", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]}, {24'd0, 1'b1, 1'b1, 4'd1, 2'd1});

    // mute mid half-period, then restart
    do_reset();
    note = 2; octave = 1;
    repeat (31) tick();
    mute = 1;
    tick();
    check("mute_now", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0], o_spk[1], o_snd[1]}, 32'd0);
    mute = 0;
    tick();
    check("unmute_restart", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]}, {24'd0, 1'b1, 1'b1, 4'd2, 2'd1});

    // rest request waits for the boundary
    do_reset();
    note = 2; octave = 1;
    tick();
    s = cyc;
    repeat (20) tick();
    note = 0;
    len = 0;
    while (o_snd[0] && len < 500) begin tick(); len++; end
    check("rest_at_boundary", 32'(cyc - s), 32'd166);
    check("rest_speaker", {31'd0, o_spk[0]}, 32'd0);

    // reset pulse during PLAY
    do_reset();
    note = 3; octave = 1;
    repeat (51) tick();
    reset = 0;
    tick();
    check("reset_in_play", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0], o_spk[1], o_snd[1]}, 32'd0);
    reset = 1; note = 0;
    repeat (200) tick();

    // reset pulse during GAP
    do_reset();
    note = 6; octave = 1;
    repeat (10) tick();
    note = 1;
    len = 0;
    while (o_snd[0] && len < 500) begin tick(); len++; end
    repeat (5) tick();
    reset = 0;
    tick();
    check("reset_in_gap", {24'd0, o_spk[0], o_snd[0], o_note[0], o_oct[0]}, 32'd0);
    reset = 1; note = 0;
    repeat (40) tick();

    for (int r = 0; r < 150; r++) begin
      note = 4'($urandom_range(0, 9));
      octave = 2'($urandom_range(0, 3));
      mute = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 49) != 0;
      repeat ($urandom_range(1, 300)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
